// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary weight path.
//   TRITS_PER_BYTE : trits carried by one base-3 packed byte
//   MAX_PACKED     : largest legal packed byte value (3^5 - 1)
//   trit_e         : base-3 digit codes
//   weight_t       : {zero, sign} pair as consumed by the systolic array
//   trit_to_weight : digit -> {zero, sign}
//   pow3           : small constant power of three for the decoder chain
package ternary_pkg;

  localparam int         TRITS_PER_BYTE = 5;
  localparam logic [7:0] MAX_PACKED     = 8'd242;

  typedef enum logic [1:0] {
    TRIT_ZERO = 2'd0,  // weight  0
    TRIT_POS  = 2'd1,  // weight +1
    TRIT_NEG  = 2'd2   // weight -1
  } trit_e;

  typedef struct packed {
    logic zero;  // 1 = weight is 0
    logic sign;  // 1 = weight is -1 (0 whenever zero is set)
  } weight_t;

  localparam weight_t WEIGHT_ZERO = '{zero: 1'b1, sign: 1'b0};

  function automatic weight_t trit_to_weight(input trit_e t);
    weight_t w;
    case (t)
      TRIT_POS: w = '{zero: 1'b0, sign: 1'b0};
      TRIT_NEG: w = '{zero: 1'b0, sign: 1'b1};
      default:  w = WEIGHT_ZERO;
    endcase
    return w;
  endfunction

  function automatic logic [7:0] pow3(input int k);
    logic [7:0] p;
    p = 8'd1;
    for (int i = 0; i < k; i++) p = p * 8'd3;
    return p;
  endfunction

endpackage

// File: rtl/ternary_weight_unpacker_trit5_decoder.sv
// trit5_decoder: combinational base-3 unpack of one byte into five weights.
//   in_byte : packed value v = sum t_k*3^k, k = 0..4
//   zero    : bit k = 1 when trit k is 0
//   sign    : bit k = 1 when trit k is 2 (weight -1)
//   invalid : byte exceeds 242; all five trits are then reported as 0
// Digits are peeled from the most significant end with a compare/subtract
// chain against 2*3^k and 3^k, so no divider is needed.
module trit5_decoder
  import ternary_pkg::*;
(
  input  logic [7:0]                in_byte,
  output logic [TRITS_PER_BYTE-1:0] zero,
  output logic [TRITS_PER_BYTE-1:0] sign,
  output logic                      invalid
);

  always_comb begin : chain
    logic [7:0] rem;
    logic [7:0] p;
    trit_e      t;
    weight_t    w;
    // NOTE: every output of a combinational block gets a default first so
    // no path through the block leaves a value held, which would be a latch.
    zero    = '1;
    sign    = '0;
    invalid = (in_byte > MAX_PACKED);
    rem     = invalid ? 8'd0 : in_byte;
    for (int k = TRITS_PER_BYTE - 1; k >= 0; k--) begin
      p = pow3(k);
      if (rem >= (p << 1)) begin
        t   = TRIT_NEG;
        rem = rem - (p << 1);
      end else if (rem >= p) begin
        t   = TRIT_POS;
        rem = rem - p;
      end else begin
        t   = TRIT_ZERO;
      end
      w       = trit_to_weight(t);
      zero[k] = w.zero;
      sign[k] = w.sign;
    end
  end

endmodule

// File: rtl/ternary_weight_unpacker.sv
// ternary_weight_unpacker: byte stream of base-3 packed ternary weights in,
// LANES {zero, sign} weights per beat out, with a small trit FIFO absorbing
// the 5-in / LANES-out rate mismatch.
//   clk, reset  : clock, synchronous active-high reset
//   in_byte     : packed weights (5 trits, trit 0 oldest)
//   in_valid    : in_byte valid
//   in_ready    : byte taken on an edge with in_valid & in_ready
//   flush       : discard every buffered trit
//   out_zero    : per lane, 1 = weight 0 (lane 0 = oldest trit)
//   out_sign    : per lane, 1 = weight -1
//   out_valid   : at least LANES trits buffered
//   out_ready   : beat taken on an edge with out_valid & out_ready
//   err_invalid : sticky, a byte 243..255 was accepted
//   level       : trits currently buffered
module ternary_weight_unpacker
  import ternary_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int BUF_TRITS = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     in_byte,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           flush,
  output logic [LANES-1:0]               out_zero,
  output logic [LANES-1:0]               out_sign,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           err_invalid,
  output logic [$clog2(BUF_TRITS+1)-1:0] level
);

  localparam int LW = $clog2(BUF_TRITS + 1);

  // Level arithmetic is done one bit wider so level + 5 cannot wrap.
  typedef logic [LW:0] lvl_ext_t;
  localparam lvl_ext_t       LANES_X = lvl_ext_t'(LANES);
  localparam lvl_ext_t       TPB_X   = lvl_ext_t'(TRITS_PER_BYTE);
  localparam lvl_ext_t       BUF_X   = lvl_ext_t'(BUF_TRITS);
  localparam logic [LW-1:0]  LANES_N = LW'(LANES);

  if (BUF_TRITS < LANES + TRITS_PER_BYTE - 1) begin : g_bad_depth
    $error("ternary_weight_unpacker: BUF_TRITS must be >= LANES+4");
  end

  weight_t                   buf_q    [BUF_TRITS];
  weight_t                   buf_d    [BUF_TRITS];
  weight_t                   shifted  [BUF_TRITS];
  weight_t                   new_w    [TRITS_PER_BYTE];
  logic [LW-1:0]             level_q;
  logic [LW-1:0]             keep;
  lvl_ext_t                  level_sum;
  logic                      push;
  logic                      pop;
  logic [TRITS_PER_BYTE-1:0] dec_zero;
  logic [TRITS_PER_BYTE-1:0] dec_sign;
  logic                      dec_invalid;
  logic                      err_q;

  trit5_decoder u_dec (
    .in_byte (in_byte),
    .zero    (dec_zero),
    .sign    (dec_sign),
    .invalid (dec_invalid)
  );

  // Handshakes look only at registered state (plus flush), so there is no
  // combinational path from in_* to out_* and in_ready ignores out_ready.
  assign out_valid = ({1'b0, level_q} >= LANES_X);
  assign in_ready  = !flush && (({1'b0, level_q} + TPB_X) <= BUF_X);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign level_sum = {1'b0, level_q} - (pop ? LANES_X : '0) + (push ? TPB_X : '0);
  // Trits that survive this edge; pop implies level_q >= LANES, no underflow.
  assign keep      = level_q - (pop ? LANES_N : '0);

  always_comb begin
    for (int j = 0; j < TRITS_PER_BYTE; j++) begin
      new_w[j] = '{zero: dec_zero[j], sign: dec_sign[j]};
    end
    for (int i = 0; i < BUF_TRITS; i++) begin
      // The modulo keeps the index in range for lanes that shift in from
      // beyond the end; those are replaced with zero weights anyway.
      shifted[i] = (i + LANES < BUF_TRITS) ? buf_q[(i + LANES) % BUF_TRITS] : WEIGHT_ZERO;
    end
    // Survivors compact to the head, the new byte lands right behind them,
    // and every slot past the new level reads as a zero weight.
    for (int i = 0; i < BUF_TRITS; i++) begin
      buf_d[i] = WEIGHT_ZERO;
      if (i < int'(keep)) begin
        buf_d[i] = pop ? shifted[i] : buf_q[i];
      end
      for (int j = 0; j < TRITS_PER_BYTE; j++) begin
        if (push && (i == int'(keep) + j)) buf_d[i] = new_w[j];
      end
    end
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      err_q   <= 1'b0;
      // NOTE: the buffer is a register file, not a RAM, and is cleared here
      // because an empty head must read as zero weights.
      for (int i = 0; i < BUF_TRITS; i++) buf_q[i] <= WEIGHT_ZERO;
    end else if (flush) begin
      level_q <= '0;
      for (int i = 0; i < BUF_TRITS; i++) buf_q[i] <= WEIGHT_ZERO;
    end else begin
      assert (level_sum <= BUF_X);
      level_q <= level_sum[LW-1:0];
      for (int i = 0; i < BUF_TRITS; i++) buf_q[i] <= buf_d[i];
      if (push && dec_invalid) err_q <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      out_zero[i] = buf_q[i].zero;
      out_sign[i] = buf_q[i].sign;
    end
  end

  assign err_invalid = err_q;
  assign level       = level_q;

endmodule
